// File: rtl/lzc_norm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lzc_norm_ctrl
//  Purpose  : Sequencer that drives an external 5-bit up/down zero counter to
//             normalise a W-bit word. It first counts the leading zeros up on
//             the counter, then shifts the word left while counting the
//             counter back down to zero.
//  Revision : 1.0  initial release
// ============================================================================
module lzc_norm_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  input  logic         cout_down,
  input  logic [4:0]   zero_sum,
  output logic         count_sel,
  output logic         five_init,
  output logic         five_en,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] norm_out,
  output logic [4:0]   lz_out
);

  // Bit-pointer width; W is at least 2, so this is at least 1.
  localparam int PW = $clog2(W);

  // The leading-zero count of an all-zero word is W, which must fit 5 bits.
  generate
    if (W < 2 || W > 31) begin : g_param_check
      $error("lzc_norm_ctrl: W must lie in 2..31");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_SNAP  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [W-1:0]  work;     // word under normalisation
  logic [PW-1:0] ptr;      // bit index being scanned, MSB first
  logic          allz;     // scan ran past bit 0 without finding a one
  logic [4:0]    lz_snap;  // counter value captured at the end of the scan

  // Counter strobes. These must be combinational: the counter clears on the
  // very edge that accepts a start, and it counts on the same edge that the
  // scan tests a zero bit or the shift moves the word.
  always_comb begin
    five_init = 1'b0;
    five_en   = 1'b0;
    count_sel = 1'b0;
    if (rst) begin
      // The counter has no reset of its own; hold it cleared during reset.
      five_init = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            five_init = 1'b1;
          end
        end
        S_SCAN: begin
          if (!work[ptr]) begin
            five_en = 1'b1;
          end
        end
        S_SHIFT: begin
          // The zero flag is the stop condition, so the counter is never
          // decremented below zero.
          if (!cout_down) begin
            five_en   = 1'b1;
            count_sel = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer state, working registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      work     <= '0;
      ptr      <= '0;
      allz     <= 1'b0;
      lz_snap  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      norm_out <= '0;
      lz_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= data_in;
            ptr   <= PW'(W - 1);
            allz  <= 1'b0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (work[ptr]) begin
            state <= S_SNAP;
          end else if (ptr != '0) begin
            ptr <= ptr - 1'b1;
          end else begin
            allz  <= 1'b1;
            state <= S_SNAP;
          end
        end
        S_SNAP: begin
          lz_snap <= zero_sum;
          if (allz) begin
            // Nothing to shift: publish directly. zero_sum is the value
            // being snapped this edge, so it is used in place of lz_snap.
            norm_out <= '0;
            lz_out   <= zero_sum;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cout_down) begin
            norm_out <= work;
            lz_out   <= lz_snap;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            work <= work << 1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lzc_norm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lzc_norm_ctrl
//  Purpose  : Self-checking bench for lzc_norm_ctrl with an attached model of
//             the external 5-bit up/down zero counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lzc_norm_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         cout_down;
  logic [4:0]   zero_sum;
  logic         count_sel;
  logic         five_init;
  logic         five_en;
  logic         busy;
  logic         done;
  logic [W-1:0] norm_out;
  logic [4:0]   lz_out;

  int vecs = 0;
  int errs = 0;

  lzc_norm_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .cout_down (cout_down),
    .zero_sum  (zero_sum),
    .count_sel (count_sel),
    .five_init (five_init),
    .five_en   (five_en),
    .busy      (busy),
    .done      (done),
    .norm_out  (norm_out),
    .lz_out    (lz_out)
  );

  always #5 clk = ~clk;

  // External counter: synchronous clear, up/down count, no reset input.
  logic [4:0] cnt;
  always @(posedge clk) begin
    if (five_init)    cnt <= 5'd0;
    else if (five_en) cnt <= count_sel ? cnt - 5'd1 : cnt + 5'd1;
  end
  assign zero_sum  = cnt;
  assign cout_down = (cnt == 5'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int ref_lz(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - 1 - i;
    end
    return W;
  endfunction

  bit           m_busy;
  bit           m_done;
  int           m_left;
  logic [W-1:0] m_norm, p_norm;
  logic [4:0]   m_lz, p_lz;

  // Job-level model: result and done pulse appear a fixed number of edges
  // after the accepting edge (2*lz+4 counting it, or W+2 for all zeros).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_left <= 0;
      m_norm <= '0; m_lz <= '0; p_norm <= '0; p_lz <= '0;
    end else if (m_done) begin
      m_done <= 0;
      m_busy <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1;
        m_norm <= p_norm;
        m_lz   <= p_lz;
      end
    end else if (start) begin
      int lz;
      lz = ref_lz(data_in);
      m_busy <= 1;
      p_lz   <= 5'(lz);
      p_norm <= (lz == W) ? '0 : data_in << lz;
      m_left <= ((lz == W) ? W + 2 : 2 * lz + 4) - 1;
    end
  end

  // Continuous compare of DUT against the model on every falling edge.
  bit sel_down_seen;
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("norm_out", {16'd0, norm_out}, {16'd0, m_norm});
    chk("lz_out", {27'd0, lz_out}, {27'd0, m_lz});
    chk("strobe_excl", {31'd0, five_en & five_init}, 32'd0);
    if (five_en && count_sel) sel_down_seen = 1;
  end

  task automatic run_job(input string tag, input logic [W-1:0] d, input bit hold_start,
                         input int exp_edge, input logic [4:0] exp_lz,
                         input logic [W-1:0] exp_norm, input logic [4:0] exp_zs,
                         input bit exp_no_shift);
    int  edges;
    bit  found;
    @(posedge clk); #2;
    sel_down_seen = 0;
    start = 1; data_in = d;
    @(posedge clk); #2;                 // edge 1: start sampled
    edges = 1;
    found = 0;
    if (!hold_start) start = 0;
    data_in = ~d;                        // must not matter once captured
    while (!found && edges < 200) begin
      @(negedge clk);
      if (done) found = 1;
      else begin @(posedge clk); #2; edges++; end
    end
    chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_latency"}, edges, exp_edge);
    chk({tag, "_lz"}, {27'd0, lz_out}, {27'd0, exp_lz});
    chk({tag, "_norm"}, {16'd0, norm_out}, {16'd0, exp_norm});
    chk({tag, "_zero_sum"}, {27'd0, zero_sum}, {27'd0, exp_zs});
    if (exp_no_shift) chk({tag, "_no_down_count"}, {31'd0, sel_down_seen}, 32'd0);
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_lz"}, {27'd0, lz_out}, {27'd0, exp_lz});
  endtask

  initial begin
    int n;
    rst = 1; start = 0; data_in = '0;
    #1;
    chk("rst_five_init0", {31'd0, five_init}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_five_init", {31'd0, five_init}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_norm", {16'd0, norm_out}, 32'd0);
      chk("rst_lz", {27'd0, lz_out}, 32'd0);
      chk("rst_zero_sum", {27'd0, zero_sum}, 32'd0);
    end
    @(posedge clk); #2;
    rst = 0;

    run_job("j0f00", 16'h0F00, 0, 12, 5'd4,  16'hF000, 5'd0,  0);
    run_job("j8001", 16'h8001, 0, 4,  5'd0,  16'h8001, 5'd0,  1);
    run_job("j0000", 16'h0000, 0, 18, 5'd16, 16'h0000, 5'd16, 1);
    run_job("j0001", 16'h0001, 1, 34, 5'd15, 16'h8000, 5'd0,  0);

    // Reset in the middle of the shift phase of a 16'h0010 job.
    @(posedge clk); #2;
    start = 1; data_in = 16'h0010;
    @(posedge clk); #2;
    start = 0;
    n = 0;
    while (!(five_en && count_sel) && n < 100) begin
      @(posedge clk); #2; n++;
    end
    chk("mid_reached_shift", {31'd0, five_en & count_sel}, 32'd1);
    rst = 1;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_norm", {16'd0, norm_out}, 32'd0);
    chk("mid_lz", {27'd0, lz_out}, 32'd0);
    chk("mid_five_init", {31'd0, five_init}, 32'd1);
    @(posedge clk); #2;
    chk("mid_cnt_cleared", {27'd0, zero_sum}, 32'd0);
    rst = 0;

    run_job("j4000", 16'h4000, 0, 6, 5'd1, 16'h8000, 5'd0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lzc_norm_ctrl.md
Name: lzc_norm_ctrl

Overview:
- Sequencing controller that drives the team's 5-bit up/down zero counter to normalise a W-bit word.
- Phase 1 scans the word MSB-first and counts leading zeros up on the counter.
- Phase 2 shifts the word left while counting the counter back down to zero, using its zero flag as the stop condition.
- Sits between an upstream requester (start/busy/done handshake) and the counter instance. The counter stays external; this block only generates its control strobes.

Parameters:
- W, 16, data word width; legal range 2..31 so the leading-zero count fits the 5-bit counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- data_in  in  W  word to normalise; sampled in the same cycle start is accepted
- cout_down  in  1  counter zero flag (counter value == 0)
- zero_sum  in  5  counter value
- count_sel  out  1  counter direction: 0 = up, 1 = down
- five_init  out  1  counter synchronous clear
- five_en  out  1  counter count enable
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle completion pulse
- norm_out  out  W  normalised word (MSB = 1 unless input was zero)
- lz_out  out  5  leading-zero count (W for an all-zero input)

Behaviour:
- Reset values: state IDLE; busy=0, done=0, norm_out=0, lz_out=0, count_sel=0, five_en=0.
- While rst=1, five_init=1 combinationally, so the counter (no reset of its own) clears on any clk edge during reset.
- Internal registers: work[W-1:0], ptr (index W-1..0), allz flag, lz_snap[4:0].
- IDLE: if start=1, set five_init=1 this cycle; capture data_in into work, ptr=W-1, allz=0; go to SCAN. If start=0, do nothing.
- SCAN: test work[ptr].
  - If bit = 1: go to SNAP with no count.
  - If bit = 0: five_en=1, count_sel=0.
    - If ptr>0: ptr decrements.
    - If ptr=0: set allz=1 and go to SNAP.
- SNAP: lz_snap<=zero_sum. If allz=1 go to DONE, otherwise go to SHIFT.
- SHIFT: if cout_down=1 go to DONE. Otherwise work<=work<<1 (zero fill), five_en=1, count_sel=1.
- DONE transition: on the edge entering DONE, norm_out<=(allz ? 0 : work) and lz_out<=lz_snap.
- DONE state: done=1 for exactly one cycle, then IDLE.
- Outputs hold until the next completion.
- five_en and five_init are never both 1. count_sel is don't-care when five_en=0 and is driven 0.
- Latency, counted as edges from the start-sampling edge until DONE is entered:
  - Nonzero input with lz leading zeros: 2*lz+4.
  - All-zero input: W+2.
- start while busy: ignored, with no effect on state or outputs.
- Reset mid-operation: immediate return to IDLE, outputs cleared. The counter is cleared on the next edge while rst is held.
- Counter is never decremented below 0 or incremented beyond W, so no wrap occurs.

Test Plan:
- Reset: hold rst 2 cycles → busy=0, done=0, norm_out=0, lz_out=0, five_init=1 throughout; zero_sum=0 after first edge.
- W=16, data_in=16'h0F00, start pulse → lz_out=4, norm_out=16'hF000. done high exactly one cycle, 12 edges after the start edge. zero_sum=0 at done.
- data_in=16'h8001 → lz_out=0, norm_out=16'h8001, done at edge 4, five_en never asserted with count_sel=1.
- data_in=16'h0000 → lz_out=16, norm_out=0, done at edge 18, no SHIFT cycles.
- data_in=16'h0001 (lz=15), start re-pulsed every cycle while busy → single result: lz_out=15, norm_out=16'h8000, done at edge 34. Extra starts are ignored.
- Assert rst during SHIFT of a 16'h0010 job → immediate IDLE, outputs 0. A following job with 16'h4000 returns lz_out=1, norm_out=16'h8000.
